aes_block_loader: RTL and testbench
===================================

# aes_block_loader

Word-to-block front end and result capture for the AES `encrypt` core. Accepts plaintext as four 32-bit words over a valid/ready stream and assembles them into a 128-bit block. It drives the core's `plaintext`, `start` and `en` inputs, waits a fixed number of cycles for the rounds to finish, then captures `cyphertext` and offers it on a 128-bit valid/ready output. Sits directly between the system bus interface and `encrypt`; `initial_key` is wired to the core independently.

## Interface
- `BUSY_CYCLES`, 12: cycles from the cycle after the `start` pulse until `cyphertext` is sampled; legal range 1–255.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `clear`  in  1  synchronous flush: drops partial block / in-flight result, returns to LOAD.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  32  plaintext word; first word of a block is most significant.
- `plaintext`  out  128  to `encrypt.plaintext`.
- `start`  out  1  to `encrypt.start`; one-cycle pulse.
- `en`  out  1  to `encrypt.en`; high while a block is in the core.
- `cyphertext`  in  128  from `encrypt.cyphertext`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  128  captured ciphertext.

## Operation
- States: LOAD, START, BUSY, HOLD. Reset state LOAD.
- LOAD: `in_ready`=1. Each `in_valid & in_ready` cycle writes `in_data` to word slot `wcnt` (slot 0 = `plaintext[127:96]`, slot 3 = `[31:0]`), and `wcnt` increments (2-bit). The handshake that fills slot 3 moves to START and wraps `wcnt` to 0.
- START: `start`=1 and `en`=1 for exactly one cycle. `busy_cnt` loads `BUSY_CYCLES`. Moves to BUSY.
- BUSY: `en`=1, and `busy_cnt` decrements each cycle. In the cycle where `busy_cnt`==1, the closing edge captures `cyphertext` into `out_data`, sets `out_valid`, and moves to HOLD.
- HOLD: `out_valid`=1 and `out_data` stable until `out_valid & out_ready`. On that handshake, clears `out_valid` and returns to LOAD.
- `in_ready`=0 in START, BUSY and HOLD. `in_valid` is ignored there, and no word is lost or consumed.
- `plaintext` register is written only in LOAD; it is stable from START through HOLD.
- `clear` (any state) has priority over all other events in that cycle:
  - next state LOAD, `wcnt`=0, `busy_cnt`=0, `out_valid`=0, `start`=0, `en`=0.
  - `plaintext` and `out_data` retain their contents.
  - A word handshake in the same cycle as `clear` is discarded.
- Reset values: `in_ready`=0 while `reset` is asserted (then 1 in LOAD); `start`=0, `en`=0, `out_valid`=0, `plaintext`=0, `out_data`=0, `wcnt`=0, `busy_cnt`=0.
- Reset mid-block or mid-BUSY discards everything. The core must be reset together with this block.

## Timing
- `start`, `en` and `out_valid` are registered outputs. `in_ready` is decoded from state only and does not depend on `in_valid`.
- If the last word's handshake is in cycle T, START is cycle T+1 (`start`=1). BUSY occupies cycles T+2 … T+1+`BUSY_CYCLES`. `out_valid` first rises in cycle T+2+`BUSY_CYCLES`.
- With default 12 and `out_ready` tied high, a new block can issue every 4+1+12+1 = 18 cycles minimum (back-to-back words).
- `cyphertext` is sampled exactly once, at the end of the last BUSY cycle; its value at any other time is don't-care.
- Gaps in `in_valid` stall LOAD with no timeout; partial blocks are held indefinitely.

## Test plan
- FIPS-197 vector: words 00112233, 44556677, 8899aabb, ccddeeff on consecutive cycles; key 000102…0f on the core.
  - Required: `plaintext`=00112233445566778899aabbccddeeff.
  - Required: `start` high for exactly one cycle at T+1.
  - Required: `out_valid` rises at T+14 with `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a.
- Gapped input (words 1 cycle apart, `in_valid` low between) -> same `plaintext` and result; `start` 1 cycle after the 4th handshake.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles after `out_valid` -> `out_data` stable and `in_ready`=0 throughout.
  - Hold `in_valid`=1 with new words during HOLD -> none accepted.
  - Then `out_ready`=1 -> LOAD next cycle, and the first new word goes into slot 0.
- `clear` after 2 words, then 4 new words (A0A0A0A0, B1B1B1B1, C2C2C2C2, D3D3D3D3) -> `plaintext`=a0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3; `clear` during BUSY -> no `out_valid`, LOAD next cycle.
- Async `reset` pulsed mid-cycle during BUSY -> all outputs at reset values before the next clock edge; `in_ready`=1 after release.
- `BUSY_CYCLES`=1 build with a stub core returning constant 0123…cdef -> `out_valid` at T+3 with that value.

Source files
------------

// File: rtl/aes_block_loader.sv
// Word-to-block front end for the AES encrypt core: assembles four 32-bit words,
// kicks the core, waits a fixed latency, then captures and offers the ciphertext.
module aes_block_loader #(
    parameter int unsigned BUSY_CYCLES = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] plaintext,
    output logic         start,
    output logic         en,
    input  logic [127:0] cyphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic               start_q, start_d;
    logic               en_q, en_d;
    logic               out_valid_q, out_valid_d;
    logic [BLK_W-1:0]   plaintext_q, plaintext_d;
    logic [BLK_W-1:0]   out_data_q, out_data_d;

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            wcnt_q      <= 2'd0;
            busy_cnt_q  <= '0;
            start_q     <= 1'b0;
            en_q        <= 1'b0;
            out_valid_q <= 1'b0;
            plaintext_q <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            busy_cnt_q  <= busy_cnt_d;
            start_q     <= start_d;
            en_q        <= en_d;
            out_valid_q <= out_valid_d;
            plaintext_q <= plaintext_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state and next-output decode; clear overrides every other event
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        busy_cnt_d  = busy_cnt_q;
        start_d     = 1'b0;
        en_d        = 1'b0;
        out_valid_d = 1'b0;
        plaintext_d = plaintext_q;
        out_data_d  = out_data_q;

        if (clear) begin
            state_d    = S_LOAD;
            wcnt_d     = 2'd0;
            busy_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        unique case (wcnt_q)
                            2'd0: plaintext_d[127:96] = in_data;
                            2'd1: plaintext_d[95:64]  = in_data;
                            2'd2: plaintext_d[63:32]  = in_data;
                            2'd3: plaintext_d[31:0]   = in_data;
                            default: ;
                        endcase
                        wcnt_d = wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) begin
                            state_d = S_START;
                            start_d = 1'b1;
                            en_d    = 1'b1;
                        end
                    end
                end
                S_START: begin
                    busy_cnt_d = CNT_W'(BUSY_CYCLES);
                    state_d    = S_BUSY;
                    en_d       = 1'b1;
                end
                S_BUSY: begin
                    busy_cnt_d = busy_cnt_q - CNT_W'(1);
                    if (busy_cnt_q == CNT_W'(1)) begin
                        out_data_d  = cyphertext;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        en_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_LOAD;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    // in_ready is a pure state decode, forced low while reset is held
    assign in_ready  = (state_q == S_LOAD) && !reset;
    assign plaintext = plaintext_q;
    assign start     = start_q;
    assign en        = en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // WORD_W documents the slot width used in the LOAD case above
    logic unused_w;
    assign unused_w = (WORD_W == 32);

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader with a latency-accurate stub core.
module tb_aes_block_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, clear, in_valid, out_ready;
    logic [31:0]  in_data;
    logic         in_ready, start, en, out_valid;
    logic [127:0] plaintext, cyphertext, out_data;

    logic         b_in_valid, b_out_ready, b_clear;
    logic [31:0]  b_in_data;
    logic         b_in_ready, b_start, b_en, b_out_valid;
    logic [127:0] b_plaintext, b_cyphertext, b_out_data;

    int checks = 0;
    int failures = 0;

    // Stub core: only the last BUSY cycle (12th after start) presents the real result
    logic [7:0]   stub_cnt;
    logic [127:0] stub_result;
    always @(posedge clk or posedge reset) begin
        if (reset) stub_cnt <= 8'd0;
        else if (start) stub_cnt <= 8'd1;
        else if (stub_cnt != 8'd0 && stub_cnt != 8'hff) stub_cnt <= stub_cnt + 8'd1;
    end
    assign cyphertext = (stub_cnt == 8'd12) ? stub_result : ({4{32'hbad0bad0}} ^ {120'd0, stub_cnt});
    assign b_cyphertext = 128'h0123456789abcdef0123456789abcdef;

    aes_block_loader #(.BUSY_CYCLES(12)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .plaintext(plaintext), .start(start), .en(en), .cyphertext(cyphertext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    aes_block_loader #(.BUSY_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .plaintext(b_plaintext), .start(b_start), .en(b_en), .cyphertext(b_cyphertext),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle T+1, where T is the cycle of the fourth handshake
    task automatic send_block(input logic [127:0] blk, input bit gapped);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = blk[127-32*i -: 32];
            tick();
            if (gapped && i < 3) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if ({start, en, out_valid} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {start, en, out_valid}); end
        checks++; if (plaintext !== 128'd0) begin failures++; $display("FAIL rst_plaintext got=%h exp=0", plaintext); end
        checks++; if (out_data !== 128'd0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fips(input bit gapped);
        int n, starts, en_low;
        stub_result = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        send_block(128'h00112233445566778899aabbccddeeff, gapped);
        checks++; if (start !== 1'b1 || en !== 1'b1) begin failures++; $display("FAIL fips_start gapped=%0d got start=%b en=%b exp=1,1", gapped, start, en); end
        checks++; if (plaintext !== 128'h00112233445566778899aabbccddeeff) begin failures++; $display("FAIL fips_plaintext got=%h exp=00112233445566778899aabbccddeeff", plaintext); end
        n = 1; starts = 0; en_low = 0;
        while (!out_valid && n < 40) begin
            tick(); n++;
            if (start) starts++;
            if (!out_valid && !en) en_low++;
        end
        checks++; if (n !== 14) begin failures++; $display("FAIL fips_latency gapped=%0d got=T+%0d exp=T+14", gapped, n); end
        checks++; if (starts !== 0) begin failures++; $display("FAIL fips_start_width extra_start_cycles=%0d exp=0", starts); end
        checks++; if (en_low !== 0) begin failures++; $display("FAIL fips_en_busy en_low_cycles=%0d exp=0", en_low); end
        checks++; if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin failures++; $display("FAIL fips_out_data got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL fips_en_hold got=%b exp=0", en); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL fips_release got ov=%b ir=%b exp=0,1", out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        int n, bad;
        stub_result = 128'hfeedfacecafebeef0011223344556677;
        send_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        checks++; if (n !== 14) begin failures++; $display("FAIL bp_latency got=T+%0d exp=T+14", n); end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 32'heeee0000 + 32'(k);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 128'hfeedfacecafebeef0011223344556677) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold_stable bad_cycles=%0d exp=0", bad); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got ir=%b ov=%b exp=1,0", in_ready, out_valid); end
        stub_result = 128'h1234;
        send_block(128'h11111111222222223333333344444444, 1'b0);
        checks++; if (plaintext !== 128'h11111111222222223333333344444444) begin failures++; $display("FAIL bp_slot0 got=%h exp=11111111222222223333333344444444", plaintext); end
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        checks++; if (out_data !== 128'h1234) begin failures++; $display("FAIL bp_second_result got=%h exp=1234", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_clear();
        int ov;
        in_valid = 1'b1; in_data = 32'h55555555; tick();
        in_data = 32'h66666666; tick();
        clear = 1'b1; in_data = 32'h99999999; tick();
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (plaintext !== 128'h55555555666666663333333344444444) begin failures++; $display("FAIL clr_partial got=%h exp=55555555666666663333333344444444", plaintext); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
        stub_result = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        send_block(128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3, 1'b0);
        checks++; if (start !== 1'b1 || plaintext !== 128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3) begin failures++; $display("FAIL clr_new_block got start=%b pt=%h exp=1,a0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3", start, plaintext); end
        tick(); tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if ({in_ready, start, en, out_valid} !== 4'b1000) begin failures++; $display("FAIL clr_busy got ir/st/en/ov=%b exp=1000", {in_ready, start, en, out_valid}); end
        ov = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (out_valid) ov++; end
        checks++; if (ov !== 0) begin failures++; $display("FAIL clr_no_result out_valid_cycles=%0d exp=0", ov); end
        checks++; if (out_data !== 128'h1234 || plaintext !== 128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3) begin failures++; $display("FAIL clr_retain got od=%h pt=%h", out_data, plaintext); end
    endtask

    task automatic test_reset_busy();
        stub_result = 128'h77;
        send_block(128'hcafef00dcafef00dcafef00dcafef00d, 1'b0);
        tick(); tick(); tick();
        #2; reset = 1'b1; #1;
        checks++; if ({in_ready, start, en, out_valid} !== 4'b0000) begin failures++; $display("FAIL arst_ctrl got ir/st/en/ov=%b exp=0000", {in_ready, start, en, out_valid}); end
        checks++; if (plaintext !== 128'd0 || out_data !== 128'd0) begin failures++; $display("FAIL arst_data got pt=%h od=%h exp=0,0", plaintext, out_data); end
        #1; reset = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_release got=%b exp=1", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1 || en !== 1'b0) begin failures++; $display("FAIL arst_after_edge got ir=%b en=%b exp=1,0", in_ready, en); end
    endtask

    task automatic test_busy_one();
        int n;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'h10101010 * 32'(i + 1);
            tick();
        end
        b_in_valid = 1'b0;
        checks++; if (b_start !== 1'b1) begin failures++; $display("FAIL b1_start got=%b exp=1", b_start); end
        n = 1;
        while (!b_out_valid && n < 10) begin tick(); n++; end
        checks++; if (n !== 3) begin failures++; $display("FAIL b1_latency got=T+%0d exp=T+3", n); end
        checks++; if (b_out_data !== 128'h0123456789abcdef0123456789abcdef) begin failures++; $display("FAIL b1_out_data got=%h exp=0123456789abcdef0123456789abcdef", b_out_data); end
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
        checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin failures++; $display("FAIL b1_release got ir=%b ov=%b exp=1,0", b_in_ready, b_out_valid); end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_clear = 1'b0; b_in_data = 32'd0;
        stub_result = 128'd0;
        test_reset();
        test_fips(1'b0);
        test_fips(1'b1);
        test_backpressure();
        test_clear();
        test_reset_busy();
        test_busy_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
